mem_arbiter: RTL and testbench

- Shares the single-port program/data RAM between the CPU memory interface and a second requester (DMA/program loader).
- Arbitrates every cycle and steers address, write data and write strobe to the RAM.
- Returns read data to the requester that issued the read, one cycle later.
- The CPU has priority, bounded by a starvation limit, so the loader always makes progress.

---
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the CPU and a DMA/loader port.
// The CPU wins contention until it has taken MAX_CPU_RUN grants in a row while
// the DMA is waiting, then the DMA gets one slot. Read data is returned to the
// requester that issued the read, one cycle after acceptance.
module mem_arbiter #(
    parameter int AW          = 9,
    parameter int DW          = 16,
    parameter int MAX_CPU_RUN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    cpu_cmd,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic [1:0]    dma_cmd,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_write,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    // 4 bits covers the full 1..15 range of the run limit
    localparam int          CW      = 4;
    localparam logic [CW-1:0] RUN_MAX = CW'(MAX_CPU_RUN);

    logic          cpu_act;
    logic          dma_act;
    logic          cpu_sel;
    logic          dma_sel;
    logic [CW-1:0] run_cnt_p1;
    logic          cpu_vld_p1;
    logic          dma_vld_p1;

    // Saturating increment keeps the run counter pinned at the limit
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        if (v >= RUN_MAX) r = RUN_MAX;
        else              r = v + 1'b1;
        return r;
    endfunction

    // Request decode and grant; reserved and NONE commands are never active
    always_comb begin
        cpu_act = (cpu_cmd == CMD_READ) || (cpu_cmd == CMD_WRITE);
        dma_act = (dma_cmd == CMD_READ) || (dma_cmd == CMD_WRITE);
        cpu_sel = reset && cpu_act && (!dma_act || (run_cnt_p1 < RUN_MAX));
        dma_sel = reset && dma_act && (!cpu_act || (run_cnt_p1 >= RUN_MAX));
    end

    assign cpu_gnt = cpu_sel;
    assign dma_gnt = dma_sel;

    // Steer the granted requester onto the RAM; idle cycles park on the CPU address
    always_comb begin
        ram_addr  = '0;
        ram_din   = '0;
        ram_write = 1'b0;
        if (dma_sel) begin
            ram_addr  = dma_addr;
            ram_din   = dma_wdata;
            ram_write = (dma_cmd == CMD_WRITE);
        end else if (reset) begin
            ram_addr  = cpu_addr;
            ram_din   = cpu_wdata;
            ram_write = cpu_sel && (cpu_cmd == CMD_WRITE);
        end
    end

    // ---- stage p1: accepted at this edge, visible next cycle ----

    // Count consecutive CPU wins while the DMA waits; any other outcome clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cnt_p1 <= '0;
        end else if (cpu_sel && dma_act) begin
            run_cnt_p1 <= sat_inc(run_cnt_p1);
        end else begin
            run_cnt_p1 <= '0;
        end
    end

    // Remember who owns the read data coming back from the RAM next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_vld_p1 <= 1'b0;
            dma_vld_p1 <= 1'b0;
        end else begin
            cpu_vld_p1 <= cpu_sel && (cpu_cmd == CMD_READ);
            dma_vld_p1 <= dma_sel && (dma_cmd == CMD_READ);
        end
    end

    assign cpu_rvalid = cpu_vld_p1;
    assign dma_rvalid = dma_vld_p1;
    assign cpu_rdata  = ram_dout;
    assign dma_rdata  = ram_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: synchronous RAM model plus a read-data scoreboard.
module tb_mem_arbiter;
    localparam int AW      = 9;
    localparam int DW      = 16;
    localparam int MAX_RUN = 4;
    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] WR   = 2'b10;
    localparam logic [1:0] RSV  = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    cpu_cmd;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic [1:0]    dma_cmd;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_write;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] ram_mem [0:511];
    bit            written [0:511];
    logic [DW-1:0] ref_mem [0:511];
    logic [DW-1:0] exp_cpu [$];
    logic [DW-1:0] exp_dma [$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_CPU_RUN(MAX_RUN)) dut (
        .clk(clk), .reset(reset),
        .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_cmd(dma_cmd), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_write(ram_write), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 9'h010)      return 16'h1111;
        else if (a == 9'h011) return 16'h2222;
        else                  return 16'hA000 | DW'(a);
    endfunction

    // Single-port synchronous RAM: data for the presented address appears next cycle
    always @(posedge clk) begin
        if (ram_write) begin
            ram_mem[ram_addr] <= ram_din;
            written[ram_addr] <= 1'b1;
        end
        ram_dout <= written[ram_addr] ? ram_mem[ram_addr] : init_val(ram_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cpu_cmd = WR; cpu_addr = 9'h005; cpu_wdata = 16'h1234;
        dma_cmd = NONE; dma_addr = '0; dma_wdata = '0;
        tick();
        tick();
        @(negedge clk);
        n_vec++;
        if (ram_write !== 1'b0 || cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL reset_gnt: ram_write=%b cpu_gnt=%b dma_gnt=%b, want 0 0 0", ram_write, cpu_gnt, dma_gnt);
        end
        n_vec++;
        if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rvalid: cpu=%b dma=%b, want 0 0", cpu_rvalid, dma_rvalid);
        end
        n_vec++;
        if (ram_addr !== 9'h000 || ram_din !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_ram_bus: addr=%h din=%h, want 000 0000", ram_addr, ram_din);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || ram_write !== 1'b1 || ram_addr !== 9'h005) begin
            n_err++;
            $display("FAIL reset_release: cpu_gnt=%b dma_gnt=%b ram_write=%b addr=%h, want 1 0 1 005",
                     cpu_gnt, dma_gnt, ram_write, ram_addr);
        end
        ref_mem[9'h005] = 16'h1234;
        tick();
        cpu_cmd = NONE;
    endtask

    task automatic test_cpu_write_read();
        logic [DW-1:0] e;
        cpu_cmd = WR; cpu_addr = 9'h005; cpu_wdata = 16'hABCD; dma_cmd = NONE;
        @(negedge clk);
        n_vec++;
        if (cpu_gnt !== 1'b1 || ram_write !== 1'b1 || ram_din !== 16'hABCD || ram_addr !== 9'h005) begin
            n_err++;
            $display("FAIL cpu_write: gnt=%b we=%b din=%h addr=%h, want 1 1 abcd 005", cpu_gnt, ram_write, ram_din, ram_addr);
        end
        ref_mem[9'h005] = 16'hABCD;
        tick();
        cpu_cmd = RD;
        @(negedge clk);
        n_vec++;
        if (cpu_gnt !== 1'b1 || ram_write !== 1'b0 || cpu_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_read_issue: gnt=%b we=%b rvalid=%b, want 1 0 0", cpu_gnt, ram_write, cpu_rvalid);
        end
        exp_cpu.push_back(ref_mem[9'h005]);
        tick();
        cpu_cmd = NONE;
        @(negedge clk);
        e = exp_cpu.pop_front();
        n_vec++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== e || dma_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL cpu_read_data: rvalid=%b rdata=%h dma_rvalid=%b, want 1 %h 0", cpu_rvalid, cpu_rdata, dma_rvalid, e);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [AW-1:0] ca;
        logic [AW-1:0] da;
        logic [DW-1:0] e;
        logic          exp_c;
        ca = 9'h020; da = 9'h040; cpu_wdata = '0; dma_wdata = '0;
        for (int i = 0; i < 21; i++) begin
            cpu_cmd = (i < 20) ? RD : NONE;
            dma_cmd = (i < 20) ? RD : NONE;
            cpu_addr = ca; dma_addr = da;
            @(negedge clk);
            n_vec++;
            if (exp_cpu.size() != 0) begin
                e = exp_cpu.pop_front();
                if (cpu_rvalid !== 1'b1 || cpu_rdata !== e) begin
                    n_err++;
                    $display("FAIL cont_cpu_rd cyc %0d: rvalid=%b rdata=%h, want 1 %h", i, cpu_rvalid, cpu_rdata, e);
                end
            end else if (cpu_rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL cont_cpu_rd cyc %0d: rvalid=%b, want 0", i, cpu_rvalid);
            end
            n_vec++;
            if (exp_dma.size() != 0) begin
                e = exp_dma.pop_front();
                if (dma_rvalid !== 1'b1 || dma_rdata !== e) begin
                    n_err++;
                    $display("FAIL cont_dma_rd cyc %0d: rvalid=%b rdata=%h, want 1 %h", i, dma_rvalid, dma_rdata, e);
                end
            end else if (dma_rvalid !== 1'b0) begin
                n_err++;
                $display("FAIL cont_dma_rd cyc %0d: rvalid=%b, want 0", i, dma_rvalid);
            end
            if (i < 20) begin
                exp_c = ((i % (MAX_RUN + 1)) != MAX_RUN);
                n_vec++;
                if (cpu_gnt !== exp_c || dma_gnt !== !exp_c || ram_write !== 1'b0 ||
                    ram_addr !== (exp_c ? ca : da)) begin
                    n_err++;
                    $display("FAIL cont_gnt cyc %0d: cpu_gnt=%b dma_gnt=%b addr=%h we=%b, want %b %b %h 0",
                             i, cpu_gnt, dma_gnt, ram_addr, ram_write, exp_c, !exp_c, exp_c ? ca : da);
                end
                if (exp_c) begin
                    exp_cpu.push_back(ref_mem[ca]);
                    ca++;
                end else begin
                    exp_dma.push_back(ref_mem[da]);
                    da++;
                end
            end
            tick();
        end
    endtask

    task automatic test_interleaved();
        logic [DW-1:0] e;
        cpu_cmd = RD; cpu_addr = 9'h010; dma_cmd = NONE;
        @(negedge clk);
        n_vec++;
        if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0 || cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL intl_t0: cpu_gnt=%b dma_gnt=%b rv=%b/%b, want 1 0 0/0", cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid);
        end
        exp_cpu.push_back(16'h1111);
        tick();
        cpu_cmd = NONE; dma_cmd = RD; dma_addr = 9'h011;
        @(negedge clk);
        e = exp_cpu.pop_front();
        n_vec++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== e || dma_rvalid !== 1'b0 || dma_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL intl_t1: cpu_rv=%b data=%h dma_rv=%b dma_gnt=%b, want 1 %h 0 1", cpu_rvalid, cpu_rdata, dma_rvalid, dma_gnt, e);
        end
        exp_dma.push_back(16'h2222);
        tick();
        dma_cmd = NONE;
        @(negedge clk);
        e = exp_dma.pop_front();
        n_vec++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== e || cpu_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL intl_t2: dma_rv=%b data=%h cpu_rv=%b, want 1 %h 0", dma_rvalid, dma_rdata, cpu_rvalid, e);
        end
        tick();
    endtask

    task automatic test_reserved_idle();
        logic [DW-1:0] e;
        cpu_cmd = RSV; cpu_addr = 9'h033; cpu_wdata = 16'hFFFF; dma_cmd = NONE;
        @(negedge clk);
        n_vec++;
        if (cpu_gnt !== 1'b0 || dma_gnt !== 1'b0 || ram_write !== 1'b0 || ram_addr !== 9'h033) begin
            n_err++;
            $display("FAIL rsv_idle: gnt=%b/%b we=%b addr=%h, want 0/0 0 033", cpu_gnt, dma_gnt, ram_write, ram_addr);
        end
        tick();
        dma_cmd = WR; dma_addr = 9'h0F0; dma_wdata = 16'h5A5A;
        @(negedge clk);
        n_vec++;
        if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rsv_no_rvalid: cpu=%b dma=%b, want 0 0", cpu_rvalid, dma_rvalid);
        end
        n_vec++;
        if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0 || ram_write !== 1'b1 || ram_addr !== 9'h0F0 || ram_din !== 16'h5A5A) begin
            n_err++;
            $display("FAIL dma_write: dma_gnt=%b cpu_gnt=%b we=%b addr=%h din=%h, want 1 0 1 0f0 5a5a",
                     dma_gnt, cpu_gnt, ram_write, ram_addr, ram_din);
        end
        ref_mem[9'h0F0] = 16'h5A5A;
        tick();
        dma_cmd = RD;
        @(negedge clk);
        n_vec++;
        if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL dma_read_issue: dma_gnt=%b cpu_gnt=%b, want 1 0", dma_gnt, cpu_gnt);
        end
        exp_dma.push_back(ref_mem[9'h0F0]);
        tick();
        cpu_cmd = NONE; dma_cmd = NONE;
        @(negedge clk);
        e = exp_dma.pop_front();
        n_vec++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== e || cpu_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL dma_readback: rv=%b data=%h cpu_rv=%b, want 1 %h 0", dma_rvalid, dma_rdata, cpu_rvalid, e);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic exp_c;
        cpu_cmd = RD; dma_cmd = RD; cpu_addr = 9'h060; dma_addr = 9'h070;
        cpu_wdata = '0; dma_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
                n_err++;
                $display("FAIL mrst_warm cyc %0d: cpu_gnt=%b dma_gnt=%b, want 1 0", i, cpu_gnt, dma_gnt);
            end
            tick();
        end
        @(negedge clk);
        n_vec++;
        if (cpu_rvalid !== 1'b1) begin
            n_err++;
            $display("FAIL mrst_pending: cpu_rvalid=%b, want 1", cpu_rvalid);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0 || cpu_gnt !== 1'b0 || dma_gnt !== 1'b0) begin
            n_err++;
            $display("FAIL mrst_drop: rv=%b/%b gnt=%b/%b, want 0/0 0/0", cpu_rvalid, dma_rvalid, cpu_gnt, dma_gnt);
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_vec++;
                if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin
                    n_err++;
                    $display("FAIL mrst_after: rv=%b/%b, want 0/0", cpu_rvalid, dma_rvalid);
                end
            end
            exp_c = ((i % (MAX_RUN + 1)) != MAX_RUN);
            n_vec++;
            if (cpu_gnt !== exp_c || dma_gnt !== !exp_c) begin
                n_err++;
                $display("FAIL mrst_runcnt cyc %0d: cpu_gnt=%b dma_gnt=%b, want %b %b", i, cpu_gnt, dma_gnt, exp_c, !exp_c);
            end
            tick();
        end
        cpu_cmd = NONE; dma_cmd = NONE;
        exp_cpu.delete();
        exp_dma.delete();
        tick();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = init_val(AW'(i));
        reset = 1'b0;
        cpu_cmd = NONE; cpu_addr = '0; cpu_wdata = '0;
        dma_cmd = NONE; dma_addr = '0; dma_wdata = '0;
        test_reset();
        test_cpu_write_read();
        test_contention();
        test_interleaved();
        test_reserved_idle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
